// File: rtl/alu_pipe_if.sv
// rtl/alu_pipe_if.sv - operand/result handshake bundle for alu_pipe
interface alu_pipe_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic             zero;
    logic             negative;
    logic             busy;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, carry, overflow, zero, negative, busy
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, carry, overflow, zero, negative, busy
    );
endinterface

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - handshaked WIDTH-bit ALU with registered flags and iterative shift-add multiply
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    alu_pipe_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_NOR = 3'b111;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t             r_state;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_result;
    logic               r_carry;
    logic               r_overflow;
    logic               r_zero;
    logic               r_negative;
    logic               r_busy;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_count;

    logic               w_in_ready;
    logic               w_in_fire;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH-1:0]   w_alu_res;
    logic               w_alu_c;
    logic               w_alu_v;
    logic [2*WIDTH-1:0] w_acc_next;
    logic               w_mul_last;

    assign w_in_ready = (r_state == S_IDLE) && (!r_out_valid || bus.out_ready);
    assign w_in_fire  = bus.in_valid && w_in_ready;

    assign w_sum  = {1'b0, bus.a} + {1'b0, bus.b};
    assign w_diff = {1'b0, bus.a} - {1'b0, bus.b};

    always_comb begin
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        w_alu_v   = 1'b0;
        case (bus.op)
            OP_ADD: begin
                w_alu_res = w_sum[WIDTH-1:0];
                w_alu_c   = w_sum[WIDTH];
                w_alu_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                // the extra top bit of the widened difference is the borrow
                w_alu_res = w_diff[WIDTH-1:0];
                w_alu_c   = w_diff[WIDTH];
                w_alu_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (w_diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AND: w_alu_res = bus.a & bus.b;
            OP_OR:  w_alu_res = bus.a | bus.b;
            OP_XOR: w_alu_res = bus.a ^ bus.b;
            OP_SLT: w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_NOR: w_alu_res = ~(bus.a | bus.b);
            default: w_alu_res = '0;
        endcase
    end

    // multiplicand shifts left and multiplier shifts right, one partial product per cycle
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_mul_last = (r_count == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_carry     <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b0;
            r_negative  <= 1'b0;
            r_busy      <= 1'b0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_count     <= '0;
        end else begin
            if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_in_fire) begin
                        if (bus.op == OP_MUL) begin
                            r_state  <= S_MUL;
                            r_busy   <= 1'b1;
                            r_acc    <= '0;
                            r_count  <= '0;
                            r_mcand  <= {{WIDTH{1'b0}}, bus.a};
                            r_mplier <= bus.b;
                        end else begin
                            r_result    <= w_alu_res;
                            r_carry     <= w_alu_c;
                            r_overflow  <= w_alu_v;
                            r_zero      <= (w_alu_res == '0);
                            r_negative  <= w_alu_res[WIDTH-1];
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + 1'b1;
                    if (w_mul_last) begin
                        r_state     <= S_IDLE;
                        r_busy      <= 1'b0;
                        r_count     <= '0;
                        r_result    <= w_acc_next[WIDTH-1:0];
                        r_carry     <= |w_acc_next[2*WIDTH-1:WIDTH];
                        r_overflow  <= 1'b0;
                        r_zero      <= (w_acc_next[WIDTH-1:0] == '0);
                        r_negative  <= w_acc_next[WIDTH-1];
                        r_out_valid <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.carry     = r_carry;
    assign bus.overflow  = r_overflow;
    assign bus.zero      = r_zero;
    assign bus.negative  = r_negative;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - randomized and directed bench for alu_pipe against an arithmetic reference
module tb_alu_pipe;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         v;
        logic         z;
        logic         n;
        int           due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   mul_done = 0;
    logic fire_seen = 1'b0;
    exp_t q[$];

    alu_pipe_if #(.WIDTH(W)) bus ();

    alu_pipe #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: true-integer arithmetic, then reduce to W bits and range-test for flags
    function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        longint ux = longint'(x);
        longint uy = longint'(y);
        longint sx = ux >= (64'sd1 << (W - 1)) ? ux - (64'sd1 << W) : ux;
        longint sy = uy >= (64'sd1 << (W - 1)) ? uy - (64'sd1 << W) : uy;
        longint m = 64'sd1 << W;
        longint smax = (m / 2) - 1;
        longint smin = -(m / 2);
        longint t = 0;
        e.c = 1'b0;
        e.v = 1'b0;
        e.due = 0;
        case (o)
            3'd0: begin t = ux + uy; e.c = (t >= m); e.v = (sx + sy > smax) || (sx + sy < smin); end
            3'd1: begin t = ux - uy + m; e.c = (ux < uy); e.v = (sx - sy > smax) || (sx - sy < smin); end
            3'd2: t = longint'(x & y);
            3'd3: t = longint'(x | y);
            3'd4: t = longint'(x ^ y);
            3'd5: t = (sx < sy) ? 64'sd1 : 64'sd0;
            3'd6: begin t = ux * uy; e.c = (t >= m); end
            default: t = longint'(~(x | y));
        endcase
        e.r = W'(t % m);
        e.z = (e.r == 0);
        e.n = (longint'(e.r) >= m / 2);
        return e;
    endfunction

    always @(negedge clk) begin
        logic exp_busy;
        logic exp_valid;
        exp_t e;
        if (rst) begin
            chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
            chk("rst.result", 32'(bus.result), 32'd0);
            chk("rst.flags", 32'({bus.carry, bus.overflow, bus.zero, bus.negative, bus.busy}), 32'd0);
            q.delete();
            mul_done = 0;
            fire_seen = 1'b0;
        end else begin
            exp_busy  = (cyc < mul_done);
            exp_valid = (q.size() > 0) && (q[0].due <= cyc);
            chk("busy", 32'(bus.busy), 32'(exp_busy));
            chk("out_valid", 32'(bus.out_valid), 32'(exp_valid));
            chk("in_ready", 32'(bus.in_ready), 32'(!exp_busy && (!exp_valid || bus.out_ready)));
            if (exp_valid && bus.out_valid) begin
                chk("result", 32'(bus.result), 32'(q[0].r));
                chk("flags", 32'({bus.carry, bus.overflow, bus.zero, bus.negative}),
                    32'({q[0].c, q[0].v, q[0].z, q[0].n}));
            end
            if (exp_valid && bus.out_ready) void'(q.pop_front());
            fire_seen = bus.in_valid && bus.in_ready;
            if (fire_seen) begin
                e = model(bus.op, bus.a, bus.b);
                e.due = cyc + 1 + ((bus.op == 3'd6) ? W : 0);
                if (bus.op == 3'd6) mul_done = cyc + 1 + W;
                q.push_back(e);
            end
        end
    end

    task automatic send(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        int t = 0;
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.op = o; bus.a = x; bus.b = y;
        while (!bus.in_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 100) chk("send_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [W-1:0] r, input logic [3:0] cvzn);
        int t = 0;
        @(negedge clk);
        while (!bus.out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk({name, ".valid"}, 32'(bus.out_valid), 32'd1);
        chk({name, ".result"}, 32'(bus.result), 32'(r));
        chk({name, ".cvzn"}, 32'({bus.carry, bus.overflow, bus.zero, bus.negative}), 32'(cvzn));
    endtask

    function automatic logic [W-1:0] rnd_operand();
        logic [W-1:0] corners [5] = '{8'h00, 8'h7F, 8'h80, 8'hFF, 8'h01};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        return W'($urandom);
    endfunction

    initial begin
        logic [W-1:0] held;
        logic [W-1:0] stream_exp [4] = '{8'h88, 8'hEE, 8'h66, 8'h11};
        logic [2:0]   stream_op  [4] = '{3'd2, 3'd3, 3'd4, 3'd7};
        bus.in_valid = 1'b0; bus.op = 3'd0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b1;
        @(negedge clk);
        chk("reset.in_ready", 32'(bus.in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        send(3'd0, 8'hF0, 8'h20); expect_out("add_carry", 8'h10, 4'b1000);
        send(3'd0, 8'h7F, 8'h01); expect_out("add_ovf",   8'h80, 4'b0101);
        send(3'd1, 8'h80, 8'h01); expect_out("sub_ovf",   8'h7F, 4'b0100);
        send(3'd1, 8'h01, 8'h02); expect_out("sub_brw",   8'hFF, 4'b1001);
        send(3'd5, 8'hFF, 8'h01); expect_out("slt",       8'h01, 4'b0000);

        send(3'd6, 8'd15, 8'd17);
        for (int k = 1; k <= W; k++) begin
            @(negedge clk);
            chk("mul.busy_window", 32'({bus.busy, bus.in_ready, bus.out_valid}), 32'b100);
        end
        expect_out("mul_15x17", 8'hFF, 4'b0001);
        chk("mul.busy_after", 32'(bus.busy), 32'd0);
        send(3'd6, 8'd16, 8'd16); expect_out("mul_16x16", 8'h00, 4'b1010);

        // backpressure: hold the first result, second bundle must wait for out_ready
        @(posedge clk); #1 bus.out_ready = 1'b0;
        send(3'd0, 8'h11, 8'h22);
        bus.in_valid = 1'b1; bus.op = 3'd1; bus.a = 8'h50; bus.b = 8'h10;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp.hold_result", 32'(bus.result), 32'h33);
            chk("bp.in_ready_low", 32'(bus.in_ready), 32'd0);
        end
        @(posedge clk); #1 bus.out_ready = 1'b1;
        #1 chk("bp.in_ready_rise", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1 bus.in_valid = 1'b0;
        chk("bp.second", 32'(bus.result), 32'h40);

        for (int i = 0; i <= 4; i++) begin
            @(posedge clk); #1;
            if (i < 4) begin
                bus.in_valid = 1'b1; bus.op = stream_op[i]; bus.a = 8'hCC; bus.b = 8'hAA;
                chk("stream.in_ready", 32'(bus.in_ready), 32'd1);
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            if (i > 0) chk("stream.result", 32'({bus.out_valid, bus.result}), 32'({1'b1, stream_exp[i-1]}));
        end

        send(3'd6, 8'd3, 8'd5);
        @(posedge clk); @(posedge clk); #1 rst = 1'b1;
        #1 chk("mid_mul_rst.outs", 32'({bus.out_valid, bus.busy, bus.result}), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        #1 chk("post_rst.in_ready", 32'(bus.in_ready), 32'd1);
        send(3'd0, 8'd1, 8'd1); expect_out("post_rst_add", 8'h02, 4'b0000);

        repeat (500) begin
            @(posedge clk); #1;
            if (!bus.in_valid || fire_seen) begin
                bus.in_valid = ($urandom_range(0, 9) < 7);
                bus.op = 3'($urandom_range(0, 7));
                bus.a = rnd_operand();
                bus.b = rnd_operand();
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1 bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("drain.queue_empty", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
